// File: rtl/refill_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/writebacks,
// arbitrating round-robin on ties and sequencing fixed-length line bursts.
module refill_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // I-cache refill requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_abort,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_done,
  // D-cache refill / writeback requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_done,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // status
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = CNT_W + 2;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST_I = 2'd1,
    S_BURST_D = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic              r_last_grant, w_nxt_last_grant;
  logic              r_aborted, w_nxt_aborted;
  logic [ADDR_W-1:0] r_base, w_nxt_base;
  logic              r_d_we, w_nxt_d_we;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [1:0]        r_grant;
  logic              r_busy;
  logic              r_i_done;
  logic              r_d_done;

  logic              w_beat;
  logic              w_i_elig;
  logic              w_pick_i;
  logic              w_nxt_burst;
  logic              w_nxt_mem_we;
  logic [ADDR_W-1:0] w_nxt_mem_addr;
  logic [1:0]        w_nxt_grant;
  logic              w_nxt_i_done;
  logic              w_nxt_d_done;

  // Next-state, burst sequencing and next values of the registered outputs
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_last_grant = r_last_grant;
    w_nxt_aborted    = r_aborted;
    w_nxt_base       = r_base;
    w_nxt_d_we       = r_d_we;

    w_beat   = r_mem_req & mem_ack;
    w_i_elig = i_req & ~i_abort;
    w_pick_i = w_i_elig & (~d_req | (r_last_grant == SIDE_D));

    case (r_state)
      S_IDLE: begin
        if (w_pick_i) begin
          w_nxt_state      = S_BURST_I;
          w_nxt_base       = i_addr & BASE_MASK;
          w_nxt_cnt        = '0;
          w_nxt_last_grant = SIDE_I;
        end else if (d_req) begin
          w_nxt_state      = S_BURST_D;
          w_nxt_base       = d_addr & BASE_MASK;
          w_nxt_d_we       = d_we;
          w_nxt_cnt        = '0;
          w_nxt_last_grant = SIDE_D;
        end
      end
      S_BURST_I, S_BURST_D: begin
        // a flush only poisons the I burst; the beats still run to keep the bus sane
        if ((r_state == S_BURST_I) && i_abort) begin
          w_nxt_aborted = 1'b1;
        end
        if (w_beat) begin
          if (r_cnt == LAST_BEAT) begin
            w_nxt_cnt   = '0;
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_nxt_state   = S_IDLE;
        w_nxt_aborted = 1'b0;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    w_nxt_burst    = (w_nxt_state == S_BURST_I) || (w_nxt_state == S_BURST_D);
    w_nxt_mem_we   = (w_nxt_state == S_BURST_D) & w_nxt_d_we;
    w_nxt_mem_addr = w_nxt_burst ? (w_nxt_base | ADDR_W'({w_nxt_cnt, 2'b00})) : '0;
    w_nxt_grant    = {w_nxt_state == S_BURST_D, w_nxt_state == S_BURST_I};
    w_nxt_i_done   = (w_nxt_state == S_DONE) & (r_state == S_BURST_I) & ~w_nxt_aborted;
    w_nxt_d_done   = (w_nxt_state == S_DONE) & (r_state == S_BURST_D);
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= SIDE_D;
      r_aborted    <= 1'b0;
      r_base       <= '0;
      r_d_we       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_grant      <= 2'b00;
      r_busy       <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_last_grant <= w_nxt_last_grant;
      r_aborted    <= w_nxt_aborted;
      r_base       <= w_nxt_base;
      r_d_we       <= w_nxt_d_we;
      r_mem_req    <= w_nxt_burst;
      r_mem_we     <= w_nxt_mem_we;
      r_mem_addr   <= w_nxt_mem_addr;
      r_grant      <= w_nxt_grant;
      r_busy       <= (w_nxt_state != S_IDLE);
      r_i_done     <= w_nxt_i_done;
      r_d_done     <= w_nxt_d_done;
    end
  end

  // Per-beat handshakes follow mem_ack in the same cycle
  assign i_valid   = (r_state == S_BURST_I) & r_mem_req & mem_ack & ~r_aborted & ~i_abort;
  assign d_valid   = (r_state == S_BURST_D) & r_mem_req & mem_ack & ~r_d_we;
  assign d_wready  = (r_state == S_BURST_D) & r_mem_req & mem_ack &  r_d_we;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_wdata = d_wdata;

  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign grant    = r_grant;
  assign busy     = r_busy;
  assign i_done   = r_i_done;
  assign d_done   = r_d_done;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed + randomized bench for refill_arbiter against a transaction-level model.
module tb_refill_arbiter;

  localparam int LW = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req, i_abort, i_valid, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_wready, d_valid, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  bit          m_last_d;
  int unsigned ack_pct;
  bit          ack_q[$];

  refill_arbiter #(.LINE_WORDS(LW), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort),
    .i_rdata(i_rdata), .i_valid(i_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wready(d_wready), .d_rdata(d_rdata), .d_valid(d_valid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: on a tie the side not served last wins; a flushed I request is ineligible
  function automatic int pick(input bit ir, input bit ia, input bit dr, input bit last_d);
    bit ie;
    ie = ir & !ia;
    if (ie && dr) return last_d ? 1 : 2;
    if (ie) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  function automatic bit next_ack();
    if (ack_q.size() != 0) return ack_q.pop_front();
    return ($urandom_range(0, 99) < ack_pct);
  endfunction

  task automatic chk_zero(input string tag);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_grant"}, 32'(grant), 32'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_i_valid"}, i_valid, 1'b0);
    chk1({tag, "_d_valid"}, d_valid, 1'b0);
    chk1({tag, "_i_done"}, i_done, 1'b0);
    chk1({tag, "_d_done"}, d_done, 1'b0);
    chk1({tag, "_d_wready"}, d_wready, 1'b0);
  endtask

  // One idle cycle in which new requests are presented; nothing may be granted yet
  task automatic idle_req(input bit ir, input bit ia, input bit dr,
                          input logic [31:0] ir_addr, input logic [31:0] dr_addr, input bit dwe);
    @(negedge clk);
    i_req = ir; i_abort = ia; d_req = dr;
    i_addr = ir_addr; d_addr = dr_addr; d_we = dwe;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1;
    chk1("idle_mem_req", mem_req, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk32("idle_grant", 32'(grant), 32'h0);
    chk1("idle_i_done", i_done, 1'b0);
    chk1("idle_d_done", d_done, 1'b0);
    chk1("idle_i_valid", i_valid, 1'b0);
    chk1("idle_d_valid", d_valid, 1'b0);
    chk1("idle_d_wready", d_wready, 1'b0);
  endtask

  // Expected burst: LW beats at base+4k, one per ack, then a single DONE cycle
  task automatic run_burst(input bit side_d, input logic [31:0] addr, input bit we,
                           input int abort_at, input bit drop_req, input int stop_after);
    logic [31:0] base;
    int beats;
    bit aborted, ack, abt;
    base = addr & ~32'(LW * 4 - 1);
    beats = 0;
    aborted = 1'b0;
    while (beats < LW && beats < stop_after) begin
      @(negedge clk);
      ack = next_ack();
      abt = side_d ? ($urandom_range(0, 3) == 0) : (!aborted && beats == abort_at);
      mem_ack = ack; mem_rdata = $urandom; d_wdata = $urandom; i_abort = abt;
      if (abt && !side_d) i_req = 1'b0;
      #1;
      chk1("burst_mem_req", mem_req, 1'b1);
      chk32("burst_grant", 32'(grant), side_d ? 32'd2 : 32'd1);
      chk1("burst_busy", busy, 1'b1);
      chk32("burst_mem_addr", mem_addr, base + 32'(4 * beats));
      chk1("burst_mem_we", mem_we, side_d & we);
      chk32("mem_wdata", mem_wdata, d_wdata);
      if (side_d) begin
        chk1("d_valid", d_valid, ack & !we);
        chk1("d_wready", d_wready, ack & we);
        chk1("i_valid_in_d", i_valid, 1'b0);
        if (ack && !we) chk32("d_rdata", d_rdata, mem_rdata);
      end else begin
        chk1("i_valid", i_valid, ack & !aborted & !abt);
        chk1("d_valid_in_i", d_valid, 1'b0);
        chk1("d_wready_in_i", d_wready, 1'b0);
        if (ack) chk32("i_rdata", i_rdata, mem_rdata);
      end
      if (abt && !side_d) aborted = 1'b1;
      if (ack) beats++;
    end
    if (beats < LW) return;
    @(negedge clk);
    mem_ack = 1'($urandom); i_abort = 1'b0;
    if (drop_req) begin
      if (side_d) d_req = 1'b0;
      else i_req = 1'b0;
    end
    #1;
    chk1("done_mem_req", mem_req, 1'b0);
    chk32("done_grant", 32'(grant), 32'h0);
    chk1("done_busy", busy, 1'b1);
    chk1("i_done", i_done, !side_d && !aborted);
    chk1("d_done", d_done, side_d);
    chk1("done_i_valid", i_valid, 1'b0);
    chk1("done_d_valid", d_valid, 1'b0);
    chk1("done_d_wready", d_wready, 1'b0);
    m_last_d = side_d;
  endtask

  initial begin
    int w;
    bit rwe;
    rst_n = 1'b0;
    i_req = 1'b1; i_abort = 1'b0; i_addr = 32'h1234;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h0;
    mem_ack = 1'b1; mem_rdata = 32'hdead_beef;
    ack_pct = 100;

    // reset state with requests and acks active
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b1;
    m_last_d = 1'b1;

    // single I refill, memory always ready
    ack_pct = 100;
    idle_req(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b0);
    run_burst(1'b0, 32'h0000_1234, 1'b0, -1, 1'b1, LW);

    // D writeback against a stalling memory
    ack_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idle_req(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0040, 1'b1);
    run_burst(1'b1, 32'h8000_0040, 1'b1, -1, 1'b1, LW);

    // I refill flushed after its first beat while D waits; D is served next
    idle_req(1'b1, 1'b0, 1'b1, 32'h0000_2468, 32'h0000_0300, 1'b0);
    w = pick(1'b1, 1'b0, 1'b1, m_last_d);
    run_burst(w == 2, (w == 2) ? 32'h0000_0300 : 32'h0000_2468, 1'b0, 1, 1'b1, LW);
    idle_req(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0300, 1'b0);
    run_burst(1'b1, 32'h0000_0300, 1'b0, -1, 1'b1, LW);

    // async reset after two beats of a D burst
    rwe = 1'($urandom);
    idle_req(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_5558, rwe);
    run_burst(1'b1, 32'h0000_5558, rwe, -1, 1'b0, 2);
    @(posedge clk);
    #1;
    chk32("pre_reset_mem_addr", mem_addr, 32'h0000_5558);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last_d = 1'b1;
    idle_req(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_5558, rwe);
    run_burst(1'b1, 32'h0000_5558, rwe, -1, 1'b1, LW);

    // tie from reset with both requests held: I, D, I
    @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk_zero("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    m_last_d = 1'b1;
    ack_pct = 70;
    for (int k = 0; k < 3; k++) begin
      idle_req(1'b1, 1'b0, 1'b1, 32'h0000_A00C, 32'h0000_B004, 1'b0);
      w = pick(1'b1, 1'b0, 1'b1, m_last_d);
      if (w == 2) run_burst(1'b1, 32'h0000_B004, 1'b0, -1, 1'b0, LW);
      else run_burst(1'b0, 32'h0000_A00C, 1'b0, -1, 1'b0, LW);
    end

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit ir, dr, ia, we;
      logic [31:0] ra, da;
      int ab;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      ia = ($urandom_range(0, 9) == 0);
      we = 1'($urandom_range(0, 1));
      ra = $urandom;
      da = $urandom;
      ack_pct = $urandom_range(20, 100);
      idle_req(ir, ia, dr, ra, da, we);
      w = pick(ir, ia, dr, m_last_d);
      if (w == 1) begin
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
        run_burst(1'b0, ra, 1'b0, ab, 1'b1, LW);
      end else if (w == 2) begin
        run_burst(1'b1, da, we, -1, 1'b1, LW);
      end
    end
    idle_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
